// File: rtl/s_ram_dp_be_init.sv
// s_ram_dp_be_init: simple-dual-port synchronous RAM (one write port, one read
// port, one clock) with per-byte write enables, selectable read-during-write
// behaviour, optional output register, read-valid strobe and a sequential
// clear engine that zeroes the whole array after reset or on request.
module s_ram_dp_be_init #(
    parameter int ADD_SIZE  = 4,
    parameter int RAM_WIDTH = 8,
    parameter int BE_W      = RAM_WIDTH / 8,
    parameter bit OUT_REG   = 1'b0,
    parameter bit RDW_MODE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 write,
    input  logic [ADD_SIZE-1:0]  wr_add,
    input  logic [BE_W-1:0]      wr_be,
    input  logic [RAM_WIDTH-1:0] d_in,
    input  logic                 read,
    input  logic [ADD_SIZE-1:0]  rd_add,
    output logic [RAM_WIDTH-1:0] d_out,
    output logic                 d_valid
);

    localparam int                DEPTH    = 2 ** ADD_SIZE;
    localparam logic [ADD_SIZE-1:0] LAST_ADD = ADD_SIZE'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADD_SIZE-1:0]   r_clr_ptr;
    logic [RAM_WIDTH-1:0]  r_mem [DEPTH];
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_collide;
    logic [RAM_WIDTH-1:0]  w_rd_word;

    // Ports are dead while the sweep owns the array.
    assign busy      = (r_state == ST_CLEAR);
    assign w_wr_en   = write & ~busy;
    assign w_rd_en   = read & ~busy;
    assign w_collide = w_wr_en & (wr_add == rd_add);

    // State register: reset lands in CLEAR so the array is always swept at start-up.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_CLEAR;
        else      r_state <= w_state_nxt;
    end

    // Next-state: finish the sweep on the last word, restart it on clr from READY.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_ptr == LAST_ADD) w_state_nxt = ST_READY;
            ST_READY: if (clr)                   w_state_nxt = ST_CLEAR;
            default:                             w_state_nxt = ST_CLEAR;
        endcase
    end

    // Sweep pointer: advances while clearing, parked at 0 otherwise so a new sweep starts at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     r_clr_ptr <= '0;
        else if (r_state == ST_CLEAR) r_clr_ptr <= r_clr_ptr + ADD_SIZE'(1);
        else                          r_clr_ptr <= '0;
    end

    // Array write: sweep zeroes one word per cycle, otherwise byte-masked port write.
    // NOTE: the array has no reset so it maps onto RAM macros; the sweep provides known contents.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be[k]) r_mem[wr_add][8*k +: 8] <= d_in[8*k +: 8];
            end
        end
    end

    // Read word: the stored word, with enabled write bytes forwarded on a collision in new-data mode.
    always_comb begin
        w_rd_word = r_mem[rd_add];
        if (RDW_MODE && w_collide) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be[k]) w_rd_word[8*k +: 8] = d_in[8*k +: 8];
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [RAM_WIDTH-1:0] r_stage_data;
            logic                 r_stage_vld;

            // Stage register: captures the read word at the first edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_stage_data <= '0;
                    r_stage_vld  <= 1'b0;
                end else begin
                    r_stage_vld <= w_rd_en;
                    if (w_rd_en) r_stage_data <= w_rd_word;
                end
            end

            // Output register: presents the staged word at the second edge, holds otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    d_out   <= '0;
                    d_valid <= 1'b0;
                end else begin
                    d_valid <= r_stage_vld;
                    if (r_stage_vld) d_out <= r_stage_data;
                end
            end
        end else begin : g_no_out_reg
            // Output register: presents the read word one edge after the request, holds otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    d_out   <= '0;
                    d_valid <= 1'b0;
                end else begin
                    d_valid <= w_rd_en;
                    if (w_rd_en) d_out <= w_rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_s_ram_dp_be_init.sv
// tb_s_ram_dp_be_init: drives two 16-bit instances from shared inputs:
// dut_a (latency 1, old-data collisions) and dut_b (latency 2, new-data
// collisions), against hand-computed expected values.
module tb_s_ram_dp_be_init;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        write;
    logic [3:0]  wr_add;
    logic [1:0]  wr_be;
    logic [15:0] d_in;
    logic        read;
    logic [3:0]  rd_add;
    logic        busy_a, busy_b;
    logic [15:0] d_out_a, d_out_b;
    logic        d_valid_a, d_valid_b;

    int n_vec  = 0;
    int n_fail = 0;

    s_ram_dp_be_init #(.ADD_SIZE(4), .RAM_WIDTH(16), .OUT_REG(1'b0), .RDW_MODE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .write(write), .wr_add(wr_add), .wr_be(wr_be), .d_in(d_in),
        .read(read), .rd_add(rd_add), .d_out(d_out_a), .d_valid(d_valid_a)
    );

    s_ram_dp_be_init #(.ADD_SIZE(4), .RAM_WIDTH(16), .OUT_REG(1'b1), .RDW_MODE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .write(write), .wr_add(wr_add), .wr_be(wr_be), .d_in(d_in),
        .read(read), .rd_add(rd_add), .d_out(d_out_b), .d_valid(d_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [1:0]  be;
        logic [15:0] din;
        logic        rd;
        logic [3:0]  ra;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        write = 1'b0;
        read  = 1'b0;
        clr   = 1'b0;
    endtask

    // One operation, then two edges: dut_a answers after the first, dut_b after the second.
    task automatic apply_vec(input vec_t v);
        write  = v.wr;
        wr_add = v.wa;
        wr_be  = v.be;
        d_in   = v.din;
        read   = v.rd;
        rd_add = v.ra;
        tick();
        idle();
        check("a_valid_e1", {15'd0, d_valid_a}, {15'd0, v.rd});
        check("b_valid_e1", {15'd0, d_valid_b}, 16'd0);
        if (v.rd) check("a_data", d_out_a, v.exp_a);
        tick();
        check("a_valid_e2", {15'd0, d_valid_a}, 16'd0);
        check("b_valid_e2", {15'd0, d_valid_b}, {15'd0, v.rd});
        if (v.rd) check("b_data", d_out_b, v.exp_b);
    endtask

    task automatic read_vec(input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
        vec_t v;
        v = '{1'b0, 4'd0, 2'b00, 16'h0, 1'b1, a, ea, eb};
        apply_vec(v);
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy_a && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;

        //                 wr    wa     be     din       rd    ra     exp_a     exp_b
        vecs[0]  = '{1'b1, 4'd3,  2'b11, 16'h00A5, 1'b0, 4'd0,  16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd3,  16'h00A5, 16'h00A5};
        vecs[2]  = '{1'b1, 4'd5,  2'b11, 16'h1234, 1'b0, 4'd0,  16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 4'd5,  2'b10, 16'hABCD, 1'b0, 4'd0,  16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd5,  16'hAB34, 16'hAB34};
        vecs[5]  = '{1'b1, 4'd6,  2'b00, 16'hFFFF, 1'b0, 4'd0,  16'h0000, 16'h0000};
        vecs[6]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd6,  16'h0000, 16'h0000};
        vecs[7]  = '{1'b1, 4'd7,  2'b11, 16'h0011, 1'b0, 4'd0,  16'h0000, 16'h0000};
        vecs[8]  = '{1'b1, 4'd7,  2'b11, 16'h0022, 1'b1, 4'd7,  16'h0011, 16'h0022};
        vecs[9]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd7,  16'h0022, 16'h0022};
        vecs[10] = '{1'b1, 4'd9,  2'b01, 16'h55CC, 1'b1, 4'd9,  16'h0000, 16'h00CC};
        vecs[11] = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd9,  16'h00CC, 16'h00CC};
        vecs[12] = '{1'b1, 4'd15, 2'b11, 16'hBEEF, 1'b1, 4'd3,  16'h00A5, 16'h00A5};
        vecs[13] = '{1'b0, 4'd0,  2'b00, 16'h0000, 1'b1, 4'd15, 16'hBEEF, 16'hBEEF};

        rst = 1'b0; idle(); wr_add = '0; wr_be = '0; d_in = '0; rd_add = '0;

        // Reset state and the start-up sweep length.
        tick(); tick();
        check("rst_busy_a",  {15'd0, busy_a},    16'd1);
        check("rst_busy_b",  {15'd0, busy_b},    16'd1);
        check("rst_valid_a", {15'd0, d_valid_a}, 16'd0);
        check("rst_valid_b", {15'd0, d_valid_b}, 16'd0);
        check("rst_dout_a",  d_out_a,            16'h0000);
        check("rst_dout_b",  d_out_b,            16'h0000);
        rst = 1'b1;
        count_busy(cnt);
        check("init_sweep_cycles", 16'(cnt), 16'd16);
        check("init_busy_b", {15'd0, busy_b}, 16'd0);
        for (int i = 0; i < 16; i++) read_vec(4'(i), 16'h0000, 16'h0000);

        // Table: byte enables, no-op write, collisions, wrapped top address.
        for (int i = 0; i < 14; i++) apply_vec(vecs[i]);

        // Back-to-back reads: one result per cycle, dut_b one cycle behind.
        read = 1'b1; rd_add = 4'd3;
        tick();
        check("b2b_a0", d_out_a, 16'h00A5);
        check("b2b_va0", {15'd0, d_valid_a}, 16'd1);
        rd_add = 4'd5;
        tick();
        check("b2b_a1", d_out_a, 16'hAB34);
        check("b2b_b0", d_out_b, 16'h00A5);
        check("b2b_vb0", {15'd0, d_valid_b}, 16'd1);
        rd_add = 4'd15;
        tick();
        check("b2b_a2", d_out_a, 16'hBEEF);
        check("b2b_b1", d_out_b, 16'hAB34);
        read = 1'b0;
        tick();
        check("b2b_va_end", {15'd0, d_valid_a}, 16'd0);
        check("b2b_b2", d_out_b, 16'hBEEF);
        check("b2b_vb2", {15'd0, d_valid_b}, 16'd1);
        tick();
        check("b2b_vb_end", {15'd0, d_valid_b}, 16'd0);
        check("hold_a", d_out_a, 16'hBEEF);
        check("hold_b", d_out_b, 16'hBEEF);

        // clr with a read in flight; port traffic and repeated clr ignored while busy.
        clr = 1'b1; read = 1'b1; rd_add = 4'd3;
        tick();
        check("clr_busy", {15'd0, busy_a}, 16'd1);
        check("clr_inflight_va", {15'd0, d_valid_a}, 16'd1);
        check("clr_inflight_a", d_out_a, 16'h00A5);
        write = 1'b1; wr_add = 4'd3; wr_be = 2'b11; d_in = 16'hFFFF;
        cnt = 0;
        while (busy_a && cnt < 40) begin
            tick();
            cnt++;
            if (!busy_a) idle();
            check("busy_va", {15'd0, d_valid_a}, 16'd0);
            if (cnt == 1) begin
                check("clr_inflight_vb", {15'd0, d_valid_b}, 16'd1);
                check("clr_inflight_b", d_out_b, 16'h00A5);
            end else begin
                check("busy_vb", {15'd0, d_valid_b}, 16'd0);
            end
        end
        idle();
        check("clr_sweep_cycles", 16'(cnt), 16'd16);
        for (int i = 0; i < 16; i++) read_vec(4'(i), 16'h0000, 16'h0000);

        // Reset in the middle of a sweep: outputs drop at once, sweep restarts in full.
        apply_vec('{1'b1, 4'd4,  2'b11, 16'h1357, 1'b0, 4'd0, 16'h0, 16'h0});
        apply_vec('{1'b1, 4'd12, 2'b11, 16'h4242, 1'b0, 4'd0, 16'h0, 16'h0});
        read_vec(4'd4, 16'h1357, 16'h1357);
        clr = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_busy",   {15'd0, busy_a},    16'd1);
        check("mid_rst_dout_a", d_out_a,            16'h0000);
        check("mid_rst_dout_b", d_out_b,            16'h0000);
        check("mid_rst_va",     {15'd0, d_valid_a}, 16'd0);
        tick(); tick();
        rst = 1'b1;
        count_busy(cnt);
        check("restart_sweep_cycles", 16'(cnt), 16'd16);
        read_vec(4'd12, 16'h0000, 16'h0000);
        read_vec(4'd4,  16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
